// File: rtl/alu_opcodes_pkg.sv
// ALU opcode encodings and datapath widths shared by the ALU and its users.
package alu_opcodes_pkg;

    localparam int unsigned ALU_OP_W   = 5;
    localparam int unsigned ALU_DATA_W = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_XOR  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_AND  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLTS = 5'd8,
        ALU_SLTU = 5'd9,
        ALU_EQ   = 5'd10,
        ALU_NE   = 5'd11,
        ALU_LTS  = 5'd12,
        ALU_LTU  = 5'd13,
        ALU_GES  = 5'd14,
        ALU_GEU  = 5'd15
    } alu_op_e;

endpackage

// File: rtl/alu_riscv.sv
// Combinational RISC-V style ALU: arithmetic/logic ops drive result, compare ops drive flag.
module alu_riscv
    import alu_opcodes_pkg::*;
(
    input  logic [ALU_OP_W-1:0]   operator_i,
    input  logic [ALU_DATA_W-1:0] operand_a_i,
    input  logic [ALU_DATA_W-1:0] operand_b_i,
    output logic [ALU_DATA_W-1:0] result_o,
    output logic                  flag_o
);

    logic lt_s;
    logic lt_u;
    logic eq;

    assign lt_s = $signed(operand_a_i) < $signed(operand_b_i);
    assign lt_u = operand_a_i < operand_b_i;
    assign eq   = operand_a_i == operand_b_i;

    // Decode the operator; unknown encodings fall through to result 0, flag 0.
    always_comb begin
        result_o = '0;
        flag_o   = 1'b0;
        case (operator_i)
            ALU_ADD:  result_o = operand_a_i + operand_b_i;
            ALU_SUB:  result_o = operand_a_i - operand_b_i;
            ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
            ALU_OR:   result_o = operand_a_i | operand_b_i;
            ALU_AND:  result_o = operand_a_i & operand_b_i;
            ALU_SLL:  result_o = operand_a_i << operand_b_i[4:0];
            ALU_SRL:  result_o = operand_a_i >> operand_b_i[4:0];
            ALU_SRA:  result_o = ALU_DATA_W'($signed(operand_a_i) >>> operand_b_i[4:0]);
            ALU_SLTS: result_o = {{(ALU_DATA_W-1){1'b0}}, lt_s};
            ALU_SLTU: result_o = {{(ALU_DATA_W-1){1'b0}}, lt_u};
            ALU_EQ:   flag_o   = eq;
            ALU_NE:   flag_o   = !eq;
            ALU_LTS:  flag_o   = lt_s;
            ALU_LTU:  flag_o   = lt_u;
            ALU_GES:  flag_o   = !lt_s;
            ALU_GEU:  flag_o   = !lt_u;
            default: begin
                result_o = '0;
                flag_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: search starts one past last_grant and wraps.
module rr_arbiter #(
    parameter int unsigned N   = 2,
    parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx,
    output logic           gnt_valid
);

    int unsigned idx;

    // First requester found after last_grant wins; later hits are ignored.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = (32'(last_grant) + off) % N;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration and a
// single registered, id-tagged response slot.
module alu_share_arb
    import alu_opcodes_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ALU_DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*ALU_DATA_W-1:0] req_b_i,
    input  logic [NUM_REQ*ALU_OP_W-1:0]   req_op_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [IDW-1:0]                rsp_id_o,
    output logic [ALU_DATA_W-1:0]         rsp_result_o,
    output logic                          rsp_flag_o
);

    // Requester 0 gets first priority out of reset.
    localparam logic [IDW-1:0]      LastGrantRst = IDW'(NUM_REQ - 1);
    localparam logic [ALU_OP_W-1:0] IdleOp       = ALU_ADD;

    logic [NUM_REQ-1:0]    gnt;
    logic [IDW-1:0]        gnt_idx;
    logic                  gnt_valid;
    logic                  can_accept;
    logic                  handshake;
    logic [IDW-1:0]        last_grant_q;

    logic [ALU_DATA_W-1:0] alu_a;
    logic [ALU_DATA_W-1:0] alu_b;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [ALU_DATA_W-1:0] alu_result;
    logic                  alu_flag;

    logic                  rsp_valid_q;
    logic [IDW-1:0]        rsp_id_q;
    logic [ALU_DATA_W-1:0] rsp_result_q;
    logic                  rsp_flag_q;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_rr_arbiter (
        .req        (req_valid_i),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    // The grant never looks at rsp_ready_i, so ready does not depend on itself.
    assign can_accept  = !rsp_valid_q || rsp_ready_i;
    assign handshake   = gnt_valid && can_accept && !rst_i;
    assign req_ready_o = handshake ? gnt : '0;

    // Steer the granted requester into the ALU; idle inputs stay X-free.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = IdleOp;
        if (gnt_valid) begin
            alu_a  = req_a_i[ALU_DATA_W*gnt_idx +: ALU_DATA_W];
            alu_b  = req_b_i[ALU_DATA_W*gnt_idx +: ALU_DATA_W];
            alu_op = req_op_i[ALU_OP_W*gnt_idx +: ALU_OP_W];
        end
    end

    alu_riscv u_alu (
        .operator_i  (alu_op),
        .operand_a_i (alu_a),
        .operand_b_i (alu_b),
        .result_o    (alu_result),
        .flag_o      (alu_flag)
    );

    // Response slot and round-robin pointer; drain and refill may share a cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flag_q   <= 1'b0;
            last_grant_q <= LastGrantRst;
        end else if (handshake) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= gnt_idx;
            rsp_result_q <= alu_result;
            rsp_flag_q   <= alu_flag;
            last_grant_q <= gnt_idx;
        end else if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_flag_o   = rsp_flag_q;

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares one `alu_riscv` instance between `NUM_REQ` requesters, for example the integer pipeline, the branch-compare path and the address-generation path. Each requester has its own valid/ready request channel. The block arbitrates round-robin and returns the ALU result and flag through a single registered response channel. Each response is tagged with the requester index. The block sits between the requesters and the shared combinational ALU and is the only driver of that ALU's inputs.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(NUM_REQ)`: width of the requester index.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester request accepted this cycle.
- `req_a_i`  in  NUM_REQ*32  operand A; requester i occupies bits [32i+31:32i].
- `req_b_i`  in  NUM_REQ*32  operand B, packed the same way.
- `req_op_i`  in  NUM_REQ*5  ALU opcode; requester i occupies bits [5i+4:5i]; encodings from `alu_opcodes_pkg`.
- `rsp_valid_o`  out  1  response register holds a result.
- `rsp_ready_i`  in  1  consumer takes the response.
- `rsp_id_o`  out  IDW  index of the requester that issued the response.
- `rsp_result_o`  out  32  registered `result_o` of the ALU.
- `rsp_flag_o`  out  1  registered `flag_o` of the ALU.

## Operation
- `can_accept = !rsp_valid_o | rsp_ready_i`. This gives one response slot with same-cycle drain-and-refill.
- Arbitration is round-robin over the current `req_valid_i`. The search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - The grant is a combinational function of `req_valid_i` and `last_grant` only. It never depends on `rsp_ready_i`, so there is no valid→ready loop.
- `req_ready_o[g] = can_accept` for the granted index g only. All other bits are 0. With no valid request, `req_ready_o` is all zeros.
- On handshake (`req_valid_i[g] & req_ready_o[g]`):
  - The ALU inputs are driven from requester g's operands and opcode.
  - On the next edge the response register captures `result_o`, `flag_o` and g, and `rsp_valid_o` is set.
  - `last_grant` is set to g.
- On drain (`rsp_valid_o & rsp_ready_i`) with no new handshake, `rsp_valid_o` clears. The data fields hold their last value.
- `last_grant` updates only on a handshake. A requester that is granted but blocked keeps the grant on following cycles while it stays valid.
- When no request is granted, the ALU inputs are zero with `ALU_ADD`. This keeps the ALU inputs free of X.
- The requester must hold `req_*` stable until its ready is seen. Dropping valid before acceptance is allowed; arbitration then re-evaluates.
- Opcodes are passed through unchanged. Unknown opcodes give result 0 and flag 0, which is the ALU default.

## Timing
- Reset values: `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_result_o`=0, `rsp_flag_o`=0, `last_grant`=`NUM_REQ-1` (so requester 0 has priority first).
  - During reset, `req_ready_o` is all zeros regardless of inputs.
- Latency: a request accepted at edge n appears on `rsp_*` after edge n, i.e. 1 cycle.
- Throughput: 1 operation per cycle when `rsp_ready_i` is held high.
- Backpressure: if `rsp_valid_o` is set and `rsp_ready_i` is 0, no request is accepted. The response is held stable until it is taken.
- Simultaneous drain and accept in one cycle: the response is replaced by the new one and `rsp_valid_o` stays 1. No bubble is inserted.
- Reset mid-operation: an in-flight response is discarded and a pending request is not accepted in that cycle. Requesters must re-present their requests after reset.
- Fairness: with all requesters continuously valid and `rsp_ready_i`=1, grants cycle 0,1,…,NUM_REQ-1,0,…

## Structure
- ALU opcodes come from the existing `alu_opcodes_pkg`. No new opcodes are added.
- The package gains `ALU_OP_W = 5` and `ALU_DATA_W = 32`, used for the port widths.
- `last_grant` reset value and the idle-ALU-input constant are local to the block.
- One instance of `alu_riscv` is instantiated inside.
- The round-robin selector is a natural sub-module, `rr_arbiter`. Parameter: `N`. Inputs: request vector and `last_grant`. Output: one-hot grant plus index. It is purely combinational and reusable elsewhere.
- Everything else is flat: the response register, `last_grant` register and input mux.

## Test plan
1. Single requester: requester 0 only, `ALU_ADD`, a=5, b=7, `rsp_ready_i`=1 → next cycle `rsp_valid_o`=1, `rsp_id_o`=0, `rsp_result_o`=12; the cycle after, `rsp_valid_o`=0.
2. Contention, NUM_REQ=2, both valid continuously, `rsp_ready_i`=1:
   - requester 0 sends `ALU_SUB` 10,3; requester 1 sends `ALU_SLTS` 0xFFFFFFFF,1;
   - `rsp_id_o` must be 0,1,0,1 with results 7,1 alternating.
3. Backpressure: `rsp_ready_i`=0 for 3 cycles after the first response.
   - `req_ready_o`=0 and the response stays stable for those 3 cycles.
   - Raising `rsp_ready_i` drains and refills in the same cycle with `rsp_valid_o` staying 1.
4. Flag path: requester 1 sends `ALU_LTS` a=0x80000000, b=0 → flag 1; then `ALU_GEU` with the same operands → flag 1; then `ALU_EQ` a=b=0x1234 → flag 1. All responses tagged id=1.
5. Reset mid-stream: assert `rst_i` while `rsp_valid_o`=1 and both requesters are valid.
   - Next cycle all outputs are zero and `req_ready_o`=0.
   - After release, requester 0 is granted first.
6. Valid withdrawal: requester 1 is granted but blocked, then drops valid → requester 0 is granted next. `last_grant` is unchanged by the withdrawn request.
